y86_regfile_sb: RTL
===================

Name: y86_regfile_sb

Overview:
- Parametrised successor to the single-cycle Y86 register file.
- Two combinational read ports and two clocked write ports (E and M), with optional same-cycle write-to-read bypass.
- A per-register scoreboard of outstanding writes for the pipelined core; decode uses it to detect RAW hazards and to throttle issue.
- Sits between decode (srcA/srcB, issue of dest IDs) and writeback (destE/destM, valE/valM).

Parameters:
- DATA_WID, 64, register and data width in bits.
- ADDR_WID, 4, register ID width.
- NUM_REGS, 15, implemented registers, IDs 0..NUM_REGS-1.
- RNONE, 4'hF, "no register" ID; must be >= NUM_REGS.
- BYPASS, 1, 1 = forward same-cycle writeback data to read ports; 0 = read stored value only.
- CNT_WID, 2, width of each scoreboard counter (max outstanding writes per register = 2^CNT_WID-1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- srcA  in  ADDR_WID  read port A register ID.
- srcB  in  ADDR_WID  read port B register ID.
- valA  out  DATA_WID  read data A.
- valB  out  DATA_WID  read data B.
- hazardA  out  1  srcA has an outstanding write not satisfied this cycle.
- hazardB  out  1  same for srcB.
- destE  in  ADDR_WID  writeback E register ID (RNONE = no write).
- valE  in  DATA_WID  writeback E data.
- destM  in  ADDR_WID  writeback M register ID (RNONE = no write).
- valM  in  DATA_WID  writeback M data.
- issue_valid  in  1  decode issuing an instruction with the pending dests below.
- issue_destE  in  ADDR_WID  future E destination (RNONE = none).
- issue_destM  in  ADDR_WID  future M destination (RNONE = none).
- issue_ready  out  1  issue accepted this cycle if issue_valid.
- sb_err  out  1  sticky: writeback to a register whose counter was 0.

Behaviour:
- Reset (RST_N low, asynchronous): all registers = 0, all counters = 0, sb_err = 0. Outputs remain combinational, so during reset valA/valB = 0 unless bypass applies, hazards = 0, issue_ready = 1.
- Any ID >= NUM_REGS (including RNONE):
  - on a read port: value 0, hazard 0.
  - on a dest: no write, no counter change.
- Writes at CLK rising edge. If destE == destM (valid), valM is written (M priority); the counter is decremented once.
- Reads are combinational, zero latency.
- Read data with BYPASS=1:
  - src == destM: valM.
  - else src == destE: valE.
  - else stored value.
- Read data with BYPASS=0: always the stored value; new data visible the cycle after the write.
- Scoreboard counter cnt[r], per register:
  - inc[r] = 1 if issue fires (issue_valid && issue_ready) and r is issue_destE or issue_destM. Counted once if both name r.
  - dec[r] = 1 if r is destE or destM. Counted once if both.
  - Next cnt[r] = cnt[r] + inc - dec. Simultaneous inc and dec leaves it unchanged.
  - dec with cnt[r] == 0 and no inc: cnt stays 0 and sb_err sets (cleared only by reset).
- hazardX = (cnt[srcX] > (BYPASS && dec[srcX] ? 1 : 0)). A write retiring this cycle clears the hazard only when bypass is on.
- issue_ready = 0 if any valid issue dest has cnt == 2^CNT_WID-1 and no dec on that register this cycle; otherwise 1. Independent of issue_valid (no combinational loop).
- Issue with both dests RNONE: always ready, no counter change.
- Reset asserted mid-operation drops all pending counts; the core must flush.

Test Plan:
- Reset, then read srcA=0, srcB=14 -> valA=valB=0, hazards 0, issue_ready=1, sb_err=0.
- destE=3, valE=0x1111 and destM=3, valM=0x2222 in the same cycle -> reg3=0x2222. With BYPASS=1, srcA=3 during that cycle reads 0x2222.
- Issue issue_destE=5, then read srcA=5 -> hazardA=1. Next cycle destE=5, valE=0xAB -> BYPASS=1: hazardA=0 and valA=0xAB that cycle; BYPASS=0: hazardA=1 and valA=old value, then 0xAB with hazardA=0 the following cycle.
- Three issues to reg 2 (CNT_WID=2) -> issue_ready=0 for a 4th issue to reg 2. A same-cycle writeback to reg 2 -> issue_ready=1, cnt stays 3.
- destM=7 with cnt[7]=0 -> sb_err=1 and stays 1; reg7 is still written.
- srcA=RNONE, destE=RNONE, valE=0xFFFF -> valA=0, no register changes. Assert RST_N low mid-stream -> all counters and registers read 0 immediately.

Source files
------------

// File: rtl/y86_regfile_sb.sv
// Y86 register file: two combinational read ports, E/M writeback ports with optional
// same-cycle bypass, and a per-register scoreboard of outstanding writes for hazard detection.
module y86_regfile_sb #(
    parameter int                  DATA_WID = 64,
    parameter int                  ADDR_WID = 4,
    parameter int                  NUM_REGS = 15,
    parameter logic [ADDR_WID-1:0] RNONE    = {ADDR_WID{1'b1}},
    parameter int                  BYPASS   = 1,
    parameter int                  CNT_WID  = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    output logic                hazardA,
    output logic                hazardB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM,
    input  logic                issue_valid,
    input  logic [ADDR_WID-1:0] issue_destE,
    input  logic [ADDR_WID-1:0] issue_destM,
    output logic                issue_ready,
    output logic                sb_err
);

    localparam logic [CNT_WID-1:0] CNT_MAX = {CNT_WID{1'b1}};

    logic [DATA_WID-1:0] regs_q [NUM_REGS];
    logic [CNT_WID-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_WID-1:0]  cnt_d  [NUM_REGS];
    logic                sb_err_q, sb_err_d;
    logic [NUM_REGS-1:0] inc, dec;
    logic                fire;

    logic [ADDR_WID-1:0] src    [2];
    logic [DATA_WID-1:0] rd_val [2];
    logic                rd_haz [2];

    function automatic logic id_ok(input logic [ADDR_WID-1:0] id);
        return (id != RNONE) && (int'(id) < NUM_REGS);
    endfunction

    assign fire = issue_valid && issue_ready;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec = '0;
        inc = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            dec[r] = (destE == ADDR_WID'(r)) || (destM == ADDR_WID'(r));
            inc[r] = fire && ((issue_destE == ADDR_WID'(r)) || (issue_destM == ADDR_WID'(r)));
        end
    end

    // A full counter blocks issue unless a writeback frees a slot this same cycle.
    always_comb begin
        issue_ready = 1'b1;
        if (id_ok(issue_destE) && cnt_q[issue_destE] == CNT_MAX && !dec[issue_destE])
            issue_ready = 1'b0;
        if (id_ok(issue_destM) && cnt_q[issue_destM] == CNT_MAX && !dec[issue_destM])
            issue_ready = 1'b0;
    end

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc[r] && !dec[r]) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec[r] && !inc[r]) begin
                if (cnt_q[r] == '0) sb_err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    assign src[0] = srcA;
    assign src[1] = srcB;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            rd_haz[p] = 1'b0;
            if (id_ok(src[p])) begin
                rd_val[p] = regs_q[src[p]];
                if (BYPASS != 0) begin
                    if (src[p] == destM)      rd_val[p] = valM;
                    else if (src[p] == destE) rd_val[p] = valE;
                end
                // With bypass, the write retiring now satisfies one outstanding count.
                if (BYPASS != 0 && dec[src[p]])
                    rd_haz[p] = cnt_q[src[p]] > CNT_WID'(1);
                else
                    rd_haz[p] = cnt_q[src[p]] != '0;
            end
        end
    end

    assign valA    = rd_val[0];
    assign valB    = rd_val[1];
    assign hazardA = rd_haz[0];
    assign hazardB = rd_haz[1];
    assign sb_err  = sb_err_q;

    // NOTE: the register array is reset explicitly because reads right after reset must return 0.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sb_err_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            sb_err_q <= sb_err_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
                if (dec[r]) regs_q[r] <= (destM == ADDR_WID'(r)) ? valM : valE;
            end
        end
    end

endmodule
